// File: rtl/ofifo_pkg.sv
// ofifo_pkg
// Shared constants and helpers for the output-FIFO psum transmitter.
//   COL, PSUM_BW, DEPTH, LEN_NIJ : default geometry (columns, lane width,
//                                  per-column FIFO depth, rows per kij pass)
//   clog2()                      : ceiling log2, sizes pointers and counters
//   lane_lo()                    : low bit index of a lane inside a packed row
package ofifo_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LEN_NIJ = 36;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lane_lo(input int unsigned c, input int unsigned bw);
        return c * bw;
    endfunction

endpackage

// File: rtl/ofifo_col.sv
// ofifo_col
// One psum column buffer: circular storage with extended write/read pointers.
// The pointer MSB acts as a lap bit, so full and empty are distinguished
// without a separate count register (occupancy = wptr - rptr).
//   clk, reset : clock, asynchronous active-low reset
//   push       : store din (ignored while full)
//   pop        : release the head entry (ignored while empty)
//   clear      : synchronous flush, wins over push/pop
//   din        : write lane data
//   dout       : head entry, valid before the pop edge
//   full/empty : occupancy flags from the registered pointers
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int unsigned depth = DEPTH,
    parameter int unsigned width = PSUM_BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = clog2(depth);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [width-1:0] mem_q [depth];
    logic             do_push;
    logic             do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ofifo_psum_tx.sv
// ofifo_psum_tx
// Collects per-column partial sums and transmits complete rows to the SFU.
// A row leaves only when every column holds an entry; all columns pop together.
//   clk, reset  : clock, asynchronous active-low reset
//   in          : column write data, lane c at [psum_bw*(c+1)-1 : psum_bw*c]
//   wr          : per-column write strobe
//   rd_en       : controller permits transmission
//   clear       : synchronous flush of buffers, row count and overflow flag
//   full        : per-column full (combinational, cycle-start state)
//   o_ready     : every column non-empty (combinational)
//   ofifo_valid : registered row valid, one cycle per popped row
//   ofifo_data  : registered row, held while ofifo_valid is low
//   kij_done    : pulses with the last row of each len_nij-row pass
//   ovf         : sticky, set by a write to a full column
module ofifo_psum_tx
    import ofifo_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned depth   = DEPTH,
    parameter int unsigned len_nij = LEN_NIJ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd_en,
    input  logic                   clear,
    output logic [col-1:0]         full,
    output logic                   o_ready,
    output logic                   ofifo_valid,
    output logic [psum_bw*col-1:0] ofifo_data,
    output logic                   kij_done,
    output logic                   ovf
);

    localparam int unsigned CW = (clog2(len_nij) == 0) ? 1 : clog2(len_nij);
    localparam logic [CW-1:0] LAST = CW'(len_nij - 1);

    logic [col-1:0]         empty;
    logic [psum_bw*col-1:0] row;
    logic                   pop;

    logic                   valid_q, valid_d;
    logic [psum_bw*col-1:0] data_q, data_d;
    logic                   kd_q, kd_d;
    logic                   ovf_q, ovf_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    for (genvar c = 0; c < col; c++) begin : g_col
        ofifo_col #(
            .depth (depth),
            .width (psum_bw)
        ) u_col (
            .clk   (clk),
            .reset (reset),
            .push  (wr[c]),
            .pop   (pop),
            .clear (clear),
            .din   (in[lane_lo(c, psum_bw) +: psum_bw]),
            .dout  (row[lane_lo(c, psum_bw) +: psum_bw]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    assign o_ready = ~|empty;
    assign pop     = rd_en & o_ready;

    always_comb begin
        valid_d = pop;
        data_d  = data_q;
        kd_d    = 1'b0;
        cnt_d   = cnt_q;
        // Overflow uses cycle-start full, so a same-cycle pop does not rescue the write.
        ovf_d   = ovf_q | (|(wr & full));
        if (pop) begin
            data_d = row;
            if (cnt_q == LAST) begin
                cnt_d = '0;
                kd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (clear) begin
            valid_d = 1'b0;
            kd_d    = 1'b0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            kd_q    <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            kd_q    <= kd_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ofifo_valid = valid_q;
    assign ofifo_data  = data_q;
    assign kij_done    = kd_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_ofifo_psum_tx.sv
// tb_ofifo_psum_tx
// Directed bench for ofifo_psum_tx. Expected rows are queued as they are
// written; a negedge monitor pops and compares every valid output row.
module tb_ofifo_psum_tx;

    localparam int unsigned NCOL = 8;
    localparam int unsigned BW   = 16;
    localparam int unsigned DW   = NCOL * BW;
    localparam int unsigned LEN  = 36;

    typedef struct {
        logic [DW-1:0] d;
        logic          kd;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   in;
    logic [NCOL-1:0] wr;
    logic            rd_en;
    logic            clear;
    logic [NCOL-1:0] full;
    logic            o_ready;
    logic            ofifo_valid;
    logic [DW-1:0]   ofifo_data;
    logic            kij_done;
    logic            ovf;

    int   tests = 0;
    int   fails = 0;
    int   nrows = 0;
    int   exp_row = 0;
    int   rows_before;
    exp_t q[$];

    always #5 clk = ~clk;

    ofifo_psum_tx #(
        .col     (NCOL),
        .psum_bw (BW),
        .depth   (64),
        .len_nij (LEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .wr          (wr),
        .rd_en       (rd_en),
        .clear       (clear),
        .full        (full),
        .o_ready     (o_ready),
        .ofifo_valid (ofifo_valid),
        .ofifo_data  (ofifo_data),
        .kij_done    (kij_done),
        .ovf         (ovf)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] mk_row(input int unsigned base);
        logic [DW-1:0] r;
        for (int unsigned c = 0; c < NCOL; c++) r[c*BW +: BW] = BW'(base + c);
        return r;
    endfunction

    task automatic push_exp(input logic [DW-1:0] d);
        exp_t e;
        e.d  = d;
        e.kd = (exp_row == LEN - 1);
        q.push_back(e);
        exp_row = (exp_row + 1) % LEN;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q.delete();
        exp_row = 0;
    endtask

    task automatic stream_rows(input int unsigned n, input int unsigned base);
        rd_en = 1'b1;
        for (int unsigned t = 0; t < n; t++) begin
            in = mk_row(base + t * NCOL);
            wr = '1;
            push_exp(in);
            tick();
        end
        wr = '0;
        tick();
        tick();
        tick();
        rd_en = 1'b0;
        settle();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (ofifo_valid === 1'b1) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_row observed=%h expected=no_row", ofifo_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("row_data", ofifo_data, e.d);
                check("row_kij_done", DW'(kij_done), DW'(e.kd));
                nrows++;
            end
        end else begin
            check("kij_done_idle", DW'(kij_done), '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        in    = '0;
        wr    = '0;
        rd_en = 1'b0;
        clear = 1'b0;

        // Reset held with random activity
        for (int i = 0; i < 4; i++) begin
            in    = {$urandom, $urandom, $urandom, $urandom};
            wr    = NCOL'($urandom);
            rd_en = 1'($urandom);
            settle();
            check("rst_valid", DW'(ofifo_valid), '0);
            check("rst_data", ofifo_data, '0);
            check("rst_full", DW'(full), '0);
            check("rst_ready", DW'(o_ready), '0);
            check("rst_ovf", DW'(ovf), '0);
        end
        tick();
        wr    = '0;
        rd_en = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check("post_rst_valid", DW'(ofifo_valid), '0);
        check("post_rst_ready", DW'(o_ready), '0);
        check("post_rst_data", ofifo_data, '0);

        // Skewed fill: ready only after the last column's write
        in = mk_row(16'h0100);
        for (int unsigned c = 0; c < NCOL; c++) begin
            wr = NCOL'(1 << c);
            tick();
            check("skew_ready", DW'(o_ready), DW'(c == NCOL - 1));
        end
        wr = '0;
        push_exp(mk_row(16'h0100));
        rows_before = nrows;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        settle();
        check("skew_rows", DW'(nrows - rows_before), DW'(1));
        check("skew_ready_after", DW'(o_ready), '0);
        check("skew_hold_data", ofifo_data, mk_row(16'h0100));

        // Two full passes back to back
        do_clear();
        rows_before = nrows;
        stream_rows(LEN, 0);
        check("pass1_rows", DW'(nrows - rows_before), DW'(LEN));
        rows_before = nrows;
        stream_rows(LEN, 16'h1000);
        check("pass2_rows", DW'(nrows - rows_before), DW'(LEN));
        check("pass_queue", DW'(q.size()), '0);

        // Overflow on one column
        do_clear();
        in = mk_row(16'h0500);
        for (int i = 0; i < 65; i++) begin
            wr = 8'h04;
            tick();
            if (i == 63) begin
                check("ovf_full64", DW'(full), DW'(8'h04));
                check("ovf_not_yet", DW'(ovf), '0);
            end
        end
        wr = '0;
        check("ovf_set", DW'(ovf), DW'(1));
        check("ovf_full_only2", DW'(full), DW'(8'h04));
        check("ovf_ready", DW'(o_ready), '0);
        do_clear();
        check("clr_ovf", DW'(ovf), '0);
        check("clr_ready", DW'(o_ready), '0);
        check("clr_full", DW'(full), '0);

        // Simultaneous write and pop at depth-1 and at full depth
        for (int unsigned r = 0; r < 63; r++) begin
            in = mk_row(16'h2000 + r * NCOL);
            wr = '1;
            tick();
        end
        wr = '0;
        check("sim_pre_full", DW'(full), '0);
        check("sim_pre_ready", DW'(o_ready), DW'(1));
        in = mk_row(16'h2000 + 63 * NCOL);
        wr = '1;
        rd_en = 1'b1;
        push_exp(mk_row(16'h2000));
        tick();
        wr = '0;
        rd_en = 1'b0;
        check("sim63_full", DW'(full), '0);
        check("sim63_ovf", DW'(ovf), '0);
        in = mk_row(16'h2000 + 64 * NCOL);
        wr = '1;
        tick();
        wr = '0;
        check("sim_fill_full", DW'(full), DW'(8'hFF));
        in = mk_row(16'h2000 + 65 * NCOL);
        wr = '1;
        rd_en = 1'b1;
        push_exp(mk_row(16'h2000 + NCOL));
        tick();
        wr = '0;
        rd_en = 1'b0;
        check("sim64_ovf", DW'(ovf), DW'(1));
        check("sim64_full", DW'(full), '0);
        // Drain: the dropped row must not appear
        for (int unsigned r = 2; r <= 64; r++) push_exp(mk_row(16'h2000 + r * NCOL));
        rd_en = 1'b1;
        for (int i = 0; i < 66; i++) tick();
        rd_en = 1'b0;
        settle();
        check("sim_drain_queue", DW'(q.size()), '0);
        check("sim_drain_ready", DW'(o_ready), '0);

        // Asynchronous reset while row 20 is presented
        do_clear();
        rd_en = 1'b1;
        for (int unsigned t = 0; t <= 20; t++) begin
            in = mk_row(16'h3000 + t * NCOL);
            wr = '1;
            push_exp(in);
            tick();
        end
        wr = '0;
        tick();
        rd_en = 1'b0;
        #2;
        check("arst_pre_valid", DW'(ofifo_valid), DW'(1));
        check("arst_pre_data", ofifo_data, mk_row(16'h3000 + 20 * NCOL));
        reset = 1'b0;
        #1;
        check("arst_valid", DW'(ofifo_valid), '0);
        check("arst_data", ofifo_data, '0);
        check("arst_ready", DW'(o_ready), '0);
        q.delete();
        exp_row = 0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        rows_before = nrows;
        stream_rows(LEN, 16'h4000);
        check("arst_pass_rows", DW'(nrows - rows_before), DW'(LEN));
        check("final_queue", DW'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
